// File: rtl/text_vram_arbiter_if.sv
// Bus bundle between the text-VRAM arbiter and its neighbours: scanout, CPU decode and the VRAM macro.
// slave is the arbiter's view; master is the surrounding system's view.
interface text_vram_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              vga_active;
  logic [ADDR_W-1:0] vga_address;
  logic [7:0]        vga_data;
  logic [ADDR_W-1:0] cpu_address;
  logic [7:0]        cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic              cpu_busy;
  logic [7:0]        cpu_rdata;
  logic              cpu_rvalid;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_q;

  modport slave (
    input  vga_active, vga_address, cpu_address, cpu_wdata, cpu_we, cpu_re, mem_q,
    output vga_data, cpu_busy, cpu_rdata, cpu_rvalid, mem_address, mem_wdata, mem_we
  );

  modport master (
    output vga_active, vga_address, cpu_address, cpu_wdata, cpu_we, cpu_re, mem_q,
    input  vga_data, cpu_busy, cpu_rdata, cpu_rvalid, mem_address, mem_wdata, mem_we
  );
endinterface

// File: rtl/text_vram_arbiter.sv
// Single-port text VRAM arbiter: scanout has absolute priority, CPU writes drain from a FIFO in free slots.
// Define VRAM_ARB_READBACK_EN to enable CPU reads (ordered behind buffered writes); otherwise reads are ignored.
module text_vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  text_vram_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [7:0]        fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  assign fifo_empty   = (count_q == {CNT_W{1'b0}});
  assign fifo_full    = (count_q == FULL_CNT);
  assign push         = bus.cpu_we & ~bus.cpu_busy;
  assign bus.vga_data = bus.mem_q;

`ifdef VRAM_ARB_READBACK_EN
  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              issue;

  // rd_pend drops as the address goes out, so busy is already low in the data-return cycle.
  assign bus.cpu_busy   = fifo_full | rd_pend_q;
  assign pop            = ~bus.vga_active & (state_q == IDLE) & ~fifo_empty;
  assign issue          = ~bus.vga_active & (state_q == IDLE) & fifo_empty & rd_pend_q;
  assign bus.cpu_rvalid = (state_q == RD_WAIT);
  assign bus.cpu_rdata  = (state_q == RD_WAIT) ? bus.mem_q : rdata_q;

  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d   = RD_WAIT;
          rd_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        rdata_d = bus.mem_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.cpu_re && !bus.cpu_busy) begin
      rd_pend_d = 1'b1;
      rd_addr_d = bus.cpu_address;
    end else begin
      rd_addr_d = rd_addr_d;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      rd_addr_q <= {ADDR_W{1'b0}};
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
    end
  end
`else
  assign bus.cpu_busy   = fifo_full;
  assign pop            = ~bus.vga_active & ~fifo_empty;
  assign bus.cpu_rvalid = 1'b0;
  assign bus.cpu_rdata  = 8'h00;
`endif

  always_comb begin
    bus.mem_address = fifo_addr_q[rd_ptr_q];
    bus.mem_wdata   = fifo_data_q[rd_ptr_q];
    bus.mem_we      = 1'b0;
    if (bus.vga_active) begin
      bus.mem_address = bus.vga_address;
    end else if (pop) begin
      bus.mem_we = 1'b1;
`ifdef VRAM_ARB_READBACK_EN
    end else if (issue) begin
      bus.mem_address = rd_addr_q;
`endif
    end else begin
      bus.mem_we = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
    count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  // Storage needs no reset: only entries covered by count_q are ever popped.
  always_ff @(posedge CLOCK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.cpu_address;
      fifo_data_q[wr_ptr_q] <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Directed bench for text_vram_arbiter with a behavioural 1-cycle-latency VRAM.
// Readback scenarios run only when VRAM_ARB_READBACK_EN is defined.
module tb_text_vram_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [7:0] vram [8192];

  text_vram_arbiter_if #(.ADDR_W(13)) bus ();

  text_vram_arbiter #(.ADDR_W(13), .FIFO_DEPTH(4)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) vram[bus.mem_address] <= bus.mem_wdata;
    bus.mem_q <= vram[bus.mem_address];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [12:0] a, input logic [7:0] d);
    bus.cpu_we      = 1'b1;
    bus.cpu_address = a;
    bus.cpu_wdata   = d;
    step();
    bus.cpu_we      = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (bus.cpu_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", bus.cpu_busy); end
    total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0h exp=0", bus.cpu_rvalid); end
    total++; if (bus.cpu_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", bus.cpu_rdata); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0h exp=0", bus.mem_we); end
  endtask

  task automatic test_write_latency;
    bus.vga_active = 1'b0;
    push(13'h0A2, 8'h41);
    #1;
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL wr_lat_we got=%0h exp=1", bus.mem_we); end
    total++; if (bus.mem_address !== 13'h0A2) begin bad++; $display("FAIL wr_lat_addr got=%0h exp=0a2", bus.mem_address); end
    total++; if (bus.mem_wdata !== 8'h41) begin bad++; $display("FAIL wr_lat_data got=%0h exp=41", bus.mem_wdata); end
    // back-to-back pushes drain one per cycle
    bus.cpu_we = 1'b1; bus.cpu_address = 13'h0FA5; bus.cpu_wdata = 8'h11;
    step();
    bus.cpu_address = 13'h1000; bus.cpu_wdata = 8'h22;
    #1;
    total++; if ({bus.mem_we, bus.mem_address, bus.mem_wdata} !== {1'b1, 13'h0FA5, 8'h11}) begin bad++; $display("FAIL b2b_first got=%0h/%0h/%0h exp=1/fa5/11", bus.mem_we, bus.mem_address, bus.mem_wdata); end
    step();
    bus.cpu_we = 1'b0;
    #1;
    total++; if ({bus.mem_we, bus.mem_address, bus.mem_wdata} !== {1'b1, 13'h1000, 8'h22}) begin bad++; $display("FAIL b2b_second got=%0h/%0h/%0h exp=1/1000/22", bus.mem_we, bus.mem_address, bus.mem_wdata); end
    step();
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0h exp=0", bus.mem_we); end
  endtask

  task automatic test_passthrough;
    bus.vga_active  = 1'b1;
    bus.vga_address = 13'h0A2;
    #1;
    total++; if (bus.mem_address !== 13'h0A2) begin bad++; $display("FAIL pass_addr got=%0h exp=0a2", bus.mem_address); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL pass_we got=%0h exp=0", bus.mem_we); end
    step();
    total++; if (bus.vga_data !== 8'h41) begin bad++; $display("FAIL pass_data got=%0h exp=41", bus.vga_data); end
  endtask

  task automatic test_drain;
    logic [7:0] d;
    bus.vga_active  = 1'b1;
    bus.vga_address = 13'h0A2;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h48 : 8'h49 + 8'(i);
      push(13'(2 * i), d);
      #1;
      total++; if (bus.cpu_busy !== (i == 3)) begin bad++; $display("FAIL drain_busy_push%0d got=%0h exp=%0h", i, bus.cpu_busy, (i == 3)); end
      total++; if ({bus.mem_we, bus.mem_address} !== {1'b0, 13'h0A2}) begin bad++; $display("FAIL drain_hold%0d got=%0h/%0h exp=0/0a2", i, bus.mem_we, bus.mem_address); end
    end
    // attempt while full must be dropped
    push(13'h008, 8'hEE);
    total++; if (bus.cpu_busy !== 1'b1) begin bad++; $display("FAIL drain_full_hold got=%0h exp=1", bus.cpu_busy); end
    bus.vga_active = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h48 : 8'h49 + 8'(i);
      total++; if ({bus.mem_we, bus.mem_address, bus.mem_wdata} !== {1'b1, 13'(2 * i), d}) begin bad++; $display("FAIL drain_pop%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.mem_we, bus.mem_address, bus.mem_wdata, 2 * i, d); end
      total++; if (bus.cpu_busy !== (i == 0)) begin bad++; $display("FAIL drain_busy_pop%0d got=%0h exp=%0h", i, bus.cpu_busy, (i == 0)); end
      step();
    end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL drain_extra_write got=%0h exp=0", bus.mem_we); end
    bus.vga_active  = 1'b1;
    bus.vga_address = 13'h006;
    step();
    total++; if (bus.vga_data !== 8'h4C) begin bad++; $display("FAIL drain_readback got=%0h exp=4c", bus.vga_data); end
  endtask

  task automatic test_preempt;
    bus.vga_active  = 1'b1;
    bus.vga_address = 13'h040;
    push(13'h123, 8'h9C);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL preempt_stall%0d got=%0h exp=0", i, bus.mem_we); end
      step();
    end
    bus.vga_active = 1'b0;
    #1;
    total++; if ({bus.mem_we, bus.mem_address, bus.mem_wdata} !== {1'b1, 13'h123, 8'h9C}) begin bad++; $display("FAIL preempt_write got=%0h/%0h/%0h exp=1/123/9c", bus.mem_we, bus.mem_address, bus.mem_wdata); end
    step();
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL preempt_after got=%0h exp=0", bus.mem_we); end
  endtask

`ifdef VRAM_ARB_READBACK_EN
  task automatic test_read_after_write;
    bus.vga_active  = 1'b0;
    bus.cpu_we      = 1'b1;
    bus.cpu_re      = 1'b1;
    bus.cpu_address = 13'h010;
    bus.cpu_wdata   = 8'h5A;
    step();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    #1;
    total++; if ({bus.mem_we, bus.mem_address, bus.mem_wdata} !== {1'b1, 13'h010, 8'h5A}) begin bad++; $display("FAIL raw_write got=%0h/%0h/%0h exp=1/10/5a", bus.mem_we, bus.mem_address, bus.mem_wdata); end
    total++; if (bus.cpu_busy !== 1'b1) begin bad++; $display("FAIL raw_busy got=%0h exp=1", bus.cpu_busy); end
    step();
    total++; if ({bus.mem_we, bus.mem_address, bus.cpu_rvalid} !== {1'b0, 13'h010, 1'b0}) begin bad++; $display("FAIL raw_issue got=%0h/%0h/%0h exp=0/10/0", bus.mem_we, bus.mem_address, bus.cpu_rvalid); end
    step();
    total++; if ({bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_busy} !== {1'b1, 8'h5A, 1'b0}) begin bad++; $display("FAIL raw_return got=%0h/%0h/%0h exp=1/5a/0", bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_busy); end
    step();
    total++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 8'h5A}) begin bad++; $display("FAIL raw_hold got=%0h/%0h exp=0/5a", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_read_stalled;
    int errs;
    bus.vga_active = 1'b0;
    push(13'h020, 8'h33);
    step();
    bus.vga_active  = 1'b1;
    bus.vga_address = 13'h0A2;
    bus.cpu_re      = 1'b1;
    bus.cpu_address = 13'h020;
    step();
    bus.cpu_re = 1'b0;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cpu_rvalid !== 1'b0 || bus.cpu_busy !== 1'b1 || bus.cpu_rdata !== 8'h5A) errs++;
      step();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL stall_hold got=%0d bad cycles exp=0", errs); end
    bus.vga_active = 1'b0;
    #1;
    total++; if ({bus.mem_address, bus.cpu_rvalid, bus.cpu_busy} !== {13'h020, 1'b0, 1'b1}) begin bad++; $display("FAIL stall_issue got=%0h/%0h/%0h exp=20/0/1", bus.mem_address, bus.cpu_rvalid, bus.cpu_busy); end
    step();
    total++; if ({bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_busy} !== {1'b1, 8'h33, 1'b0}) begin bad++; $display("FAIL stall_return got=%0h/%0h/%0h exp=1/33/0", bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_busy); end
    step();
  endtask
`else
  task automatic test_no_readback;
    int errs;
    bus.vga_active  = 1'b0;
    bus.cpu_re      = 1'b1;
    bus.cpu_address = 13'h0A2;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.cpu_rvalid !== 1'b0 || bus.cpu_busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.cpu_rdata !== 8'h00) errs++;
      step();
    end
    bus.cpu_re = 1'b0;
    total++; if (errs != 0) begin bad++; $display("FAIL no_readback got=%0d bad cycles exp=0", errs); end
  endtask
`endif

  task automatic test_reset_mid;
    int errs;
    bus.vga_active  = 1'b1;
    bus.vga_address = 13'h0A2;
    for (int i = 0; i < 3; i++) push(13'h030 + 13'(i), 8'hA0 + 8'(i));
`ifdef VRAM_ARB_READBACK_EN
    bus.cpu_re      = 1'b1;
    bus.cpu_address = 13'h030;
    step();
    bus.cpu_re = 1'b0;
`else
    push(13'h033, 8'hA3);
`endif
    #1;
    total++; if (bus.cpu_busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy got=%0h exp=1", bus.cpu_busy); end
    bus.vga_active = 1'b0;
    rst = 1'b1;
    #1;
    total++; if ({bus.cpu_busy, bus.cpu_rvalid, bus.cpu_rdata, bus.mem_we} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin bad++; $display("FAIL rstmid_now got=%0h/%0h/%0h/%0h exp=0/0/0/0", bus.cpu_busy, bus.cpu_rvalid, bus.cpu_rdata, bus.mem_we); end
    step();
    step();
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.mem_we !== 1'b0 || bus.cpu_rvalid !== 1'b0) errs++;
      step();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL rstmid_after got=%0d bad cycles exp=0", errs); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.vga_active  = 1'b0;
    bus.vga_address = 13'h000;
    bus.cpu_address = 13'h000;
    bus.cpu_wdata   = 8'h00;
    bus.cpu_we      = 1'b0;
    bus.cpu_re      = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    test_reset();
    test_write_latency();
    test_passthrough();
    test_drain();
    test_preempt();
`ifdef VRAM_ARB_READBACK_EN
    test_read_after_write();
    test_read_stalled();
`else
    test_no_readback();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
